la_capture_core: RTL
====================

Name: la_capture_core

Overview:
- Parametrised in-fabric logic-analyser capture engine; successor to the fixed 80-bit, 2-trigger vendor analyser instance.
- Samples DATA_W bits every sys_clk into a circular buffer.
- Applies programmable mask/value/edge trigger matching across TRIG_W inputs and retains a configurable pre-trigger window.
- Exposes a random-access readout port for a host-side bridge (JTAG/UART debug bridge, separate block).

Parameters:
- DATA_W, 80, sampled data width.
- TRIG_W, 2, trigger input count.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
- sys_clk  in  1  sample/system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  DATA_W  sampled probe bus.
- trig_i  in  TRIG_W  trigger probe inputs.
- arm_i  in  1  one-cycle pulse: start a capture.
- abort_i  in  1  one-cycle pulse: cancel a capture and return to IDLE.
- trig_mask_i  in  TRIG_W  1 = bit participates in trigger.
- trig_value_i  in  TRIG_W  level compare value for participating bits.
- trig_edge_i  in  TRIG_W  1 = bit must show the transition !value->value instead of a level.
- pre_depth_i  in  ADDR_W  pre-trigger sample count, latched at arm.
- rd_en_i  in  1  readout request.
- rd_addr_i  in  ADDR_W  logical sample index; 0 = oldest sample.
- rd_data_o  out  DATA_W  readout data.
- rd_valid_o  out  1  rd_data_o valid.
- armed_o  out  1  capture in progress (PRE, WAIT or POST).
- triggered_o  out  1  trigger accepted for the current capture.
- done_o  out  1  buffer complete and readable.
- trig_ptr_o  out  ADDR_W  physical address of the trigger sample.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; wr_ptr = 0; trig_prev = 0.
- Single-port-write, registered-read RAM, DEPTH x DATA_W.
- FSM states: IDLE, PRE, WAIT, POST, DONE.
- IDLE/DONE + arm_i:
  - latch pre = pre_depth_i, or DEPTH-1 if pre_depth_i equals 0 modulo DEPTH. pre is always in 0..DEPTH-1; with ADDR_W-bit pre_depth_i, a value of 0 means a full pre window of DEPTH-1.
  - wr_ptr keeps its current value; cnt = 0; clear triggered_o and done_o.
  - go to PRE, or to WAIT when pre == 0 (only reachable via the clamp rule if redefined; as specified, pre >= 1).
- PRE: write data_i at wr_ptr each cycle; wr_ptr++ (wraps mod DEPTH); cnt++. When cnt reaches pre, go to WAIT. Triggers are ignored in PRE.
- WAIT: keep writing and wrapping. Evaluate the trigger on the current sample:
  - match = AND over bits of (!mask | (edge ? (trig_i==value && trig_prev!=value) : trig_i==value)).
  - mask all 0 = immediate trigger.
  - On match: trig_ptr_o = wr_ptr (this sample's address); triggered_o = 1; post = DEPTH - pre - 1; go to POST, or to DONE if post == 0.
- POST: write post further samples, then go to DONE. done_o asserts the cycle after the last write. The trigger sample plus the post samples total DEPTH - pre.
- trig_prev <= trig_i every cycle in all states.
- DONE: no writes. armed_o = 0.
  - rd_en_i -> next cycle: rd_data_o = mem[(trig_ptr_o - pre + rd_addr_i) mod DEPTH], rd_valid_o = 1.
  - rd_en_i outside DONE: rd_valid_o = 0 and rd_data_o holds its value.
- armed_o = 1 in PRE, WAIT and POST.
- arm_i while armed: ignored.
- abort_i in any state: go to IDLE; clear armed_o, triggered_o and done_o. abort_i wins over a simultaneous arm_i.
- Reset mid-capture: reset values apply immediately; buffer contents are undefined.
- Trigger and arm in the same cycle from IDLE: that sample enters PRE only; no trigger.

Optional Feature:
- Macro: LA_TRIG_COUNT_EN.
- With the macro:
  - adds input trig_count_i [15:0].
  - In WAIT, each match increments a 16-bit occurrence counter; the trigger fires on the match where count+1 >= trig_count_i. Values 0 and 1 both mean first match.
  - The counter clears at arm and abort.
- Without the macro: the port is absent and the first match fires.

Test Plan (DATA_W=8, TRIG_W=2, ADDR_W=4):
1. data_i = incrementing counter from 0 at arm, pre_depth_i = 4, mask=01, value=01, edge=00, trig_i[0] rises when data=20 -> done_o the cycle after data=31 is written; read index 0..15 = 16..31; triggered_o=1.
2. Same as 1, plus a trig_i[0] pulse at data=2 (during PRE) -> pulse ignored; result identical to scenario 1.
3. Edge mode: edge=01, trig_i[0] held high from arm, falls at data=10, rises at data=12, pre=2 -> trigger sample 12; index 0..15 = 10..25.
4. pre_depth_i=0 -> pre = 15; trigger at data=40 -> index 15 = 40, index 0 = 25; done_o the cycle after data 40 is written.
5. abort_i in POST, then arm_i -> armed_o=1, triggered_o=0, done_o=0; new capture completes normally. Simultaneous arm_i+abort_i -> IDLE.
6. LA_TRIG_COUNT_EN, trig_count_i=3, level trigger on matches at data=8, 11, 14 -> trig sample 14. Reset asserted mid-POST -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/la_capture_core.sv
// la_capture_core: in-fabric logic-analyser capture engine.
// Samples data_i every sys_clk into a circular DEPTH x DATA_W buffer. A programmable
// mask/value/edge trigger selects the capture point, and a configurable pre-trigger
// window is kept. Once done_o is high the buffer is read back by logical index.
//
// Optional build macro: LA_TRIG_COUNT_EN adds trig_count_i. The trigger then fires on
// the Nth match seen in WAIT instead of the first.
//
// Ports:
//   sys_clk, rst_n     clock, asynchronous active-low reset
//   data_i             sampled probe bus
//   trig_i             trigger probe inputs
//   arm_i / abort_i    start / cancel a capture (one-cycle pulses)
//   trig_mask_i        1 = bit participates in the trigger
//   trig_value_i       level compare value
//   trig_edge_i        1 = bit must transition !value -> value
//   pre_depth_i        pre-trigger sample count (0 = DEPTH-1), latched at arm
//   trig_count_i       (LA_TRIG_COUNT_EN only) match occurrence that fires
//   rd_en_i, rd_addr_i readout request and logical index (0 = oldest)
//   rd_data_o, rd_valid_o  registered readout
//   armed_o, triggered_o, done_o, trig_ptr_o  capture status
module la_capture_core #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned TRIG_W = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [TRIG_W-1:0] trig_edge_i,
    input  logic [ADDR_W-1:0] pre_depth_i,
`ifdef LA_TRIG_COUNT_EN
    input  logic [15:0]       trig_count_i,
`endif
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              armed_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_ptr_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic [TRIG_W-1:0] trig_prev;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              match_c;
    logic              fire_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] pre_sel_c;
    logic [ADDR_W-1:0] post_c;
    logic [ADDR_W-1:0] cnt_inc_c;
    logic [ADDR_W-1:0] rd_phys_c;

    // A pre depth of 0 (mod DEPTH) selects the largest window, DEPTH-1.
    assign pre_sel_c = (pre_depth_i == '0) ? '1 : pre_depth_i;
    // DEPTH - pre - 1 in ADDR_W bits is the bitwise complement of pre.
    assign post_c    = ADDR_W'(~pre_q);
    assign cnt_inc_c = ADDR_W'(cnt + ADDR_W'(1));
    // Logical index 0 is the oldest retained sample, pre samples before the trigger.
    assign rd_phys_c = ADDR_W'(trig_ptr_o - pre_q + rd_addr_i);

    // Per-bit trigger match: unmasked bits always pass.
    always_comb begin
        match_c = 1'b1;
        for (int i = 0; i < TRIG_W; i++) begin
            if (trig_mask_i[i]) begin
                if (trig_i[i] != trig_value_i[i]) begin
                    match_c = 1'b0;
                end else if (trig_edge_i[i] && (trig_prev[i] == trig_value_i[i])) begin
                    match_c = 1'b0;
                end
            end
        end
    end

`ifdef LA_TRIG_COUNT_EN
    logic [15:0] occ_q;
    // 17-bit compare so a saturated counter never wraps back below the target.
    assign fire_c = match_c && ((17'({1'b0, occ_q}) + 17'd1) >= 17'({1'b0, trig_count_i}));
`else
    assign fire_c = match_c;
`endif

    assign wr_en_c = !abort_i && ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));

    // Capture FSM with registered status outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            cnt         <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            trig_prev   <= '0;
            armed_o     <= 1'b0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            trig_ptr_o  <= '0;
`ifdef LA_TRIG_COUNT_EN
            occ_q       <= '0;
`endif
        end else begin
            trig_prev <= trig_i;
            if (abort_i) begin
                state       <= S_IDLE;
                armed_o     <= 1'b0;
                triggered_o <= 1'b0;
                done_o      <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
                occ_q       <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            pre_q       <= pre_sel_c;
                            cnt         <= '0;
                            triggered_o <= 1'b0;
                            done_o      <= 1'b0;
                            armed_o     <= 1'b1;
                            state       <= S_PRE;
`ifdef LA_TRIG_COUNT_EN
                            occ_q       <= '0;
`endif
                        end
                    end
                    S_PRE: begin
                        wr_ptr <= ADDR_W'(wr_ptr + ADDR_W'(1));
                        cnt    <= cnt_inc_c;
                        if (cnt_inc_c == pre_q) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        wr_ptr <= ADDR_W'(wr_ptr + ADDR_W'(1));
                        if (fire_c) begin
                            trig_ptr_o  <= wr_ptr;
                            triggered_o <= 1'b1;
                            post_q      <= post_c;
                            cnt         <= '0;
                            if (post_c == '0) begin
                                state   <= S_DONE;
                                armed_o <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                state   <= S_POST;
                            end
                        end
`ifdef LA_TRIG_COUNT_EN
                        else if (match_c) begin
                            occ_q <= 16'(occ_q + 16'd1);
                        end
`endif
                    end
                    S_POST: begin
                        wr_ptr <= ADDR_W'(wr_ptr + ADDR_W'(1));
                        cnt    <= cnt_inc_c;
                        if (cnt_inc_c == post_q) begin
                            state   <= S_DONE;
                            armed_o <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Sample buffer write port; contents need no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Registered readout, only honoured once the buffer is complete.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            if (rd_en_i && (state == S_DONE)) begin
                rd_data_o  <= mem[rd_phys_c];
                rd_valid_o <= 1'b1;
            end
        end
    end

endmodule
